// File: rtl/max_pool_nch.sv
// max_pool_nch: N-channel 2x2 max-pool engine over a row-major pixel stream.
// Stride 2 pools non-overlapping 2x2 windows and drops an odd trailing row or
// column. Stride 1 pools overlapping windows with right/bottom padding, which
// produces an H x W result. The final row comes out of a FLUSH phase.
//
// Ports:
//   sclk, s_rst        clock, asynchronous active-high reset
//   frame_start        pulse: latch pool_stride/img_width/img_height, restart
//   data_in/_vld       pixel stream, all channels packed, ch0 in the LSBs
//   data_out/_vld      pooled pixel (holds its value while _vld is low)
//   data_out_last      marks the final result of the frame
//   busy               frame in progress, falls the cycle after data_out_last
//   err_overrun        sticky: a pixel arrived during FLUSH
module max_pool_nch #(
  parameter int unsigned CH_NUM = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 64,
  parameter int unsigned CNT_W  = 7,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                     sclk,
  input  logic                     s_rst,
  input  logic                     frame_start,
  input  logic                     pool_stride,
  input  logic [CNT_W-1:0]         img_width,
  input  logic [CNT_W-1:0]         img_height,
  input  logic [CH_NUM*DATA_W-1:0] data_in,
  input  logic                     data_in_vld,
  output logic [CH_NUM*DATA_W-1:0] data_out,
  output logic                     data_out_vld,
  output logic                     data_out_last,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int unsigned PIX_W = CH_NUM * DATA_W;
  localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  logic               r_stride1;
  logic [CNT_W-1:0]   r_width;
  logic [CNT_W-1:0]   r_height;
  logic [CNT_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_fcnt;
  logic [PIX_W-1:0]   r_prev_cur;   // previous pixel of the current row
  logic [PIX_W-1:0]   r_prev_top;   // previous line-buffer read
  logic               r_tail;       // stride 1: last column of the row above pending
  logic [PIX_W-1:0]   r_data;
  logic               r_vld;
  logic               r_last;
  logic               r_busy;
  logic               r_err;
  logic [PIX_W-1:0]   r_lb [MAX_W];

  logic               w_accept;
  logic               w_col_end;
  logic               w_row_end;
  logic [CNT_W-1:0]   w_s2_lastcol;
  logic [CNT_W-1:0]   w_s2_lastrow;
  logic [CNT_W-1:0]   w_lb_idx;
  logic [PIX_W-1:0]   w_rd;
  logic               w_lb_we;
  logic [PIX_W-1:0]   w_lb_wdata;

  // Per-channel maximum of two packed pixels.
  function automatic logic [PIX_W-1:0] f_max2(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0]  res;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic              gt;
    res = '0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      ea = a[k*DATA_W +: DATA_W];
      eb = b[k*DATA_W +: DATA_W];
      if (SIGNED) gt = ($signed(ea) > $signed(eb));
      else        gt = (ea > eb);
      res[k*DATA_W +: DATA_W] = gt ? ea : eb;
    end
    return res;
  endfunction

  // Stream position decode and line-buffer addressing.
  always_comb begin
    w_accept     = (r_state == S_RUN) && data_in_vld && !frame_start;
    w_col_end    = (r_col == r_width - CNT_W'(1));
    w_row_end    = (r_row == r_height - CNT_W'(1));
    // Stride 2 pools only even-sized extents; the final window ends here.
    w_s2_lastcol = {r_width[CNT_W-1:1], 1'b0} - CNT_W'(1);
    w_s2_lastrow = {r_height[CNT_W-1:1], 1'b0} - CNT_W'(1);
    if (r_state == S_FLUSH) w_lb_idx = r_fcnt;
    else if (r_stride1)     w_lb_idx = r_col;
    else                    w_lb_idx = r_col >> 1;
    w_rd       = r_lb[AW'(w_lb_idx)];
    // Stride 1 stores every pixel; stride 2 stores the horizontal max of an even row pair.
    w_lb_we    = w_accept && (r_stride1 || (!r_row[0] && r_col[0]));
    w_lb_wdata = r_stride1 ? data_in : f_max2(r_prev_cur, data_in);
  end

  // Line buffer: read-before-write at the same index.
  always_ff @(posedge sclk) begin
    if (w_lb_we) r_lb[AW'(w_lb_idx)] <= w_lb_wdata;
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_state    <= S_IDLE;
      r_stride1  <= 1'b0;
      r_width    <= '0;
      r_height   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_fcnt     <= '0;
      r_prev_cur <= '0;
      r_prev_top <= '0;
      r_tail     <= 1'b0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      if (r_last) r_busy <= 1'b0;
      if (frame_start) begin
        // Abort whatever is in flight; the old frame emits nothing further.
        r_state   <= S_RUN;
        r_stride1 <= pool_stride;
        r_width   <= img_width;
        r_height  <= img_height;
        r_col     <= '0;
        r_row     <= '0;
        r_fcnt    <= '0;
        r_tail    <= 1'b0;
        r_err     <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        // Last column of the row above, emitted in the idle slot after a row.
        if (r_tail) begin
          r_vld  <= 1'b1;
          r_data <= f_max2(r_prev_top, r_prev_cur);
          r_tail <= 1'b0;
        end
        case (r_state)
          S_RUN: begin
            if (w_accept) begin
              if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + CNT_W'(1);
              end else begin
                r_col <= r_col + CNT_W'(1);
              end
              if (r_stride1) begin
                r_prev_top <= w_rd;
                r_prev_cur <= data_in;
                if ((r_row != '0) && (r_col != '0)) begin
                  r_vld  <= 1'b1;
                  r_data <= f_max2(f_max2(r_prev_top, w_rd), f_max2(r_prev_cur, data_in));
                end
                if (w_col_end && (r_row != '0)) r_tail <= 1'b1;
                if (w_col_end && w_row_end) begin
                  r_state <= S_FLUSH;
                  r_fcnt  <= '0;
                end
              end else begin
                if (!r_col[0]) begin
                  r_prev_cur <= data_in;
                end else if (r_row[0]) begin
                  r_vld  <= 1'b1;
                  r_data <= f_max2(f_max2(w_rd, r_prev_cur), data_in);
                  r_last <= (r_row == w_s2_lastrow) && (r_col == w_s2_lastcol);
                end
                if (w_col_end && w_row_end) r_state <= S_IDLE;
              end
            end
          end
          S_FLUSH: begin
            // Walk the buffered last row; output lags the read by one entry.
            if (data_in_vld) r_err <= 1'b1;
            r_prev_top <= w_rd;
            r_fcnt     <= r_fcnt + CNT_W'(1);
            if (r_fcnt != '0) begin
              r_vld <= 1'b1;
              if (r_fcnt == r_width) begin
                r_data  <= r_prev_top;
                r_last  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_data <= f_max2(r_prev_top, w_rd);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out      = r_data;
  assign data_out_vld  = r_vld;
  assign data_out_last = r_last;
  assign busy          = r_busy;
  assign err_overrun   = r_err;

endmodule
